lsu_apb_master: RTL and testbench
=================================

# lsu_apb_master

APB initiator on the LSU side of the pipeline. It converts a single-outstanding load/store request from the memory stage into an APB setup/access transfer toward the LSU peripheral and memory banks. It forwards the funct3 size/sign code so the bank performs load extension. It also generates byte strobes and lane-replicated write data, and returns read data or an error to the pipeline.

## Interface

Parameters:
- ADDR_W, 32, width of request and APB address.
- TIMEOUT, 16, maximum consecutive ACCESS cycles with pready_i low before the transfer is aborted (valid range 1–255).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  reset; asynchronous assert, active-low.
- req_valid_i  in  1  pipeline request valid.
- req_ready_o  out  1  block can accept a request (IDLE only).
- req_we_i  in  1  1 = store, 0 = load.
- req_addr_i  in  ADDR_W  byte address.
- req_wdata_i  in  32  store data, right-aligned.
- req_funct3_i  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- rsp_valid_o  out  1  one-cycle response pulse; no backpressure.
- rsp_rdata_o  out  32  load data (0 on stores and errors).
- rsp_err_o  out  1  response is an error.
- psel_o  out  1  APB select.
- penable_o  out  1  APB enable (access phase).
- pwrite_o  out  1  APB write.
- paddr_o  out  ADDR_W  APB address (captured req_addr_i).
- pwdata_o  out  32  lane-replicated write data.
- pstrb_o  out  4  write byte strobes (0 on reads).
- pfunct_code_o  out  3  captured req_funct3_i.
- prdata_i  in  32  slave read data, already extended.
- pready_i  in  1  slave ready.
- pslverr_i  in  1  slave error.

## Operation

- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - req_ready_o=1, psel_o=0, penable_o=0.
  - A handshake (req_valid_i & req_ready_o) captures we, addr, wdata and funct3.
- Request check at handshake:
  - funct3 in {011,110,111} is illegal.
  - H/HU with addr[0]=1 is misaligned.
  - W with addr[1:0]≠0 is misaligned.
  - Illegal or misaligned: stay in IDLE and issue no APB transfer. Next cycle rsp_valid_o=1, rsp_err_o=1, rsp_rdata_o=0.
  - Legal: go to SETUP.
- SETUP: psel_o=1, penable_o=0; always go to ACCESS next.
- ACCESS: psel_o=1, penable_o=1.
  - pready_i=1: register prdata_i (loads) or 0 (stores) and pslverr_i into the response, return to IDLE, pulse rsp_valid_o next cycle.
  - pready_i=0: wait-counter increments. When it reaches TIMEOUT, the transfer is aborted: deassert psel/penable, go to IDLE, respond with err=1, rdata=0.
  - Counter clears on entry to SETUP.
- Strobes for stores:
  - B: 4'b0001<<addr[1:0].
  - H: 4'b0011<<addr[1:0].
  - W: 4'hF.
  - Loads: 4'h0.
- pwdata_o:
  - B: {4{wdata[7:0]}}.
  - H: {2{wdata[15:0]}}.
  - W: wdata.
- paddr_o, pwrite_o, pwdata_o, pstrb_o and pfunct_code_o are registered. They are constant from SETUP through the end of ACCESS and hold their last value in IDLE.
- Only one request is outstanding at a time; req_ready_o is low in SETUP and ACCESS.

## Timing

- Reset (rst_ni=0, asynchronous):
  - State is IDLE; psel_o, penable_o, pwrite_o, rsp_valid_o and rsp_err_o are 0.
  - paddr_o, pwdata_o, pstrb_o, pfunct_code_o and rsp_rdata_o are 0.
  - req_ready_o goes to 1 immediately.
  - Reset during SETUP/ACCESS drops psel/penable immediately; no response is produced for the aborted request.
- Handshake at edge k:
  - SETUP in cycle k+1 and ACCESS in cycle k+2.
  - With zero wait states, rsp_valid_o is high in cycle k+3.
  - Each wait state adds one cycle.
- Back-to-back: req_ready_o is high again in the same cycle as rsp_valid_o, giving 3 cycles per transfer minimum.
- Error responses (illegal/misaligned) arrive in cycle k+1; req_ready_o stays high.
- Timeout with TIMEOUT=N:
  - ACCESS lasts exactly N cycles with pready_i=0.
  - psel_o is low in cycle k+2+N.
  - rsp_valid_o with err=1 in cycle k+2+N.
- pready_i asserted in the same cycle the counter would reach TIMEOUT is a normal completion; ready wins.
- Response signals are valid only while rsp_valid_o=1.

## Test plan

- Reset:
  - Stimulus: assert rst_ni=0 mid-ACCESS.
  - Required: psel/penable/rsp_valid are 0 the same cycle; req_ready_o=1; no rsp_valid after release.
- LW, zero wait:
  - Stimulus: addr 0x40, funct3 010, slave prdata 0xDEADBEEF.
  - Required: pfunct_code_o=010; rsp_valid at k+3 with rdata 0xDEADBEEF, err=0.
- SB:
  - Stimulus: addr 0x43, wdata 0x000000A5.
  - Required: pstrb_o=1000, pwdata_o=0xA5A5A5A5, pwrite_o=1; rdata 0.
- Wait states:
  - Stimulus: SH at addr 0x12, wdata 0x1234; pready_i low for 3 ACCESS cycles.
  - Required: pstrb_o=1100, pwdata_o=0x12341234, all APB outputs stable; rsp at k+6.
- Timeout and slave error:
  - Stimulus A: TIMEOUT=4, pready_i never high.
  - Required A: abort after 4 ACCESS cycles; rsp err=1, rdata=0.
  - Stimulus B: pslverr_i=1 with pready_i=1.
  - Required B: rsp err=1.
- Misaligned/illegal:
  - Stimulus: LW at 0x2, LH at 0x1, and funct3 011.
  - Required: psel_o never high; err response at k+1 for each; back-to-back acceptance.

Source files
------------

// File: rtl/lsu_apb_master.sv
`default_nettype none
// ============================================================================
// Module  : lsu_apb_master
// Purpose : APB initiator for the LSU. Turns one outstanding load/store
//           request into an APB setup/access transfer with byte strobes,
//           lane-replicated write data and an access-phase timeout.
// Revision: 1.0 - initial release
// ============================================================================
module lsu_apb_master #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  input  logic [2:0]        req_funct3_i,
  output logic              rsp_valid_o,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic              pwrite_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic [31:0]       pwdata_o,
  output logic [3:0]        pstrb_o,
  output logic [2:0]        pfunct_code_o,
  input  logic [31:0]       prdata_i,
  input  logic              pready_i,
  input  logic              pslverr_i
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_e             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]  paddr_q, paddr_d;
  logic [31:0]        pwdata_q, pwdata_d;
  logic [3:0]         pstrb_q, pstrb_d;
  logic [2:0]         pfunct_q, pfunct_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q, rsp_err_d;
  logic [31:0]        rsp_rdata_q, rsp_rdata_d;

  logic               req_ok;
  logic               f3_legal;
  logic               misaligned;
  logic [3:0]         strb_new;
  logic [31:0]        wdata_new;
  logic [7:0]         cnt_inc;

  // Decode the incoming request: legality, alignment, strobes and lane data.
  // funct3[1:0] alone selects the access size once illegal codes are excluded.
  always_comb begin
    f3_legal   = 1'b0;
    misaligned = 1'b0;
    strb_new   = 4'h0;
    wdata_new  = req_wdata_i;
    unique case (req_funct3_i)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_legal = 1'b1;
      default:                                f3_legal = 1'b0;
    endcase
    unique case (req_funct3_i[1:0])
      2'b00: begin
        strb_new  = 4'b0001 << req_addr_i[1:0];
        wdata_new = {4{req_wdata_i[7:0]}};
      end
      2'b01: begin
        misaligned = req_addr_i[0];
        strb_new   = 4'b0011 << req_addr_i[1:0];
        wdata_new  = {2{req_wdata_i[15:0]}};
      end
      default: begin
        misaligned = |req_addr_i[1:0];
        strb_new   = 4'hF;
        wdata_new  = req_wdata_i;
      end
    endcase
    if (!req_we_i) begin
      strb_new = 4'h0;
    end
    req_ok = f3_legal && !misaligned;
  end

  assign cnt_inc = cnt_q + 8'd1;

  // Next-state and next-register logic for the transfer FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    pfunct_d    = pfunct_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          if (req_ok) begin
            state_d  = ST_SETUP;
            cnt_d    = 8'd0;
            pwrite_d = req_we_i;
            paddr_d  = req_addr_i;
            pwdata_d = wdata_new;
            pstrb_d  = strb_new;
            pfunct_d = req_funct3_i;
          end else begin
            // Rejected requests never reach the bus; answer next cycle.
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'h0;
          end
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        // Ready is checked first so it wins over a simultaneous timeout.
        if (pready_i) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = pslverr_i;
          rsp_rdata_d = (pwrite_q || pslverr_i) ? 32'h0 : prdata_i;
        end else if (cnt_inc == TIMEOUT_C) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 32'h0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= 32'h0;
      pstrb_q     <= 4'h0;
      pfunct_q    <= 3'b000;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      pfunct_q    <= pfunct_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready_o   = (state_q == ST_IDLE);
  assign psel_o        = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign penable_o     = (state_q == ST_ACCESS);
  assign pwrite_o      = pwrite_q;
  assign paddr_o       = paddr_q;
  assign pwdata_o      = pwdata_q;
  assign pstrb_o       = pstrb_q;
  assign pfunct_code_o = pfunct_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_rdata_o   = rsp_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_apb_master.sv
`default_nettype none
// ============================================================================
// Module  : tb_lsu_apb_master
// Purpose : Self-checking bench for lsu_apb_master with a behavioural model
//           of request legality, strobes, lane data and response timing.
// Revision: 1.0 - initial release
// ============================================================================
module tb_lsu_apb_master;

  localparam int ADDR_W = 32;
  localparam int TO     = 4;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              req_valid_i = 1'b0;
  logic              req_ready_o;
  logic              req_we_i = 1'b0;
  logic [ADDR_W-1:0] req_addr_i = '0;
  logic [31:0]       req_wdata_i = 32'h0;
  logic [2:0]        req_funct3_i = 3'b000;
  logic              rsp_valid_o;
  logic [31:0]       rsp_rdata_o;
  logic              rsp_err_o;
  logic              psel_o;
  logic              penable_o;
  logic              pwrite_o;
  logic [ADDR_W-1:0] paddr_o;
  logic [31:0]       pwdata_o;
  logic [3:0]        pstrb_o;
  logic [2:0]        pfunct_code_o;
  logic [31:0]       prdata_i = 32'h0;
  logic              pready_i = 1'b0;
  logic              pslverr_i = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  lsu_apb_master #(.ADDR_W(ADDR_W), .TIMEOUT(TO)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .req_funct3_i (req_funct3_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_rdata_o  (rsp_rdata_o),
    .rsp_err_o    (rsp_err_o),
    .psel_o       (psel_o),
    .penable_o    (penable_o),
    .pwrite_o     (pwrite_o),
    .paddr_o      (paddr_o),
    .pwdata_o     (pwdata_o),
    .pstrb_o      (pstrb_o),
    .pfunct_code_o(pfunct_code_o),
    .prdata_i     (prdata_i),
    .pready_i     (pready_i),
    .pslverr_i    (pslverr_i)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: access size in bytes from funct3.
  function automatic int sz_bytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit req_legal(input logic [2:0] f3, input logic [31:0] addr);
    bit code_ok;
    code_ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
              (f3 == 3'b100) || (f3 == 3'b101);
    return code_ok && ((int'(addr[1:0]) % sz_bytes(f3)) == 0);
  endfunction

  // Strobe: one bit per byte touched, starting at the byte offset.
  function automatic logic [3:0] exp_strb(input logic we, input logic [2:0] f3,
                                          input logic [31:0] addr);
    logic [3:0] s;
    int off;
    s = 4'h0;
    off = int'(addr[1:0]);
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (i >= off && i < off + sz_bytes(f3)) s[i] = 1'b1;
      end
    end
    return s;
  endfunction

  // Lane data: byte lane i carries data byte (i mod size).
  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) begin
      w[8*i +: 8] = wd[8*(i % sz_bytes(f3)) +: 8];
    end
    return w;
  endfunction

  // One complete request; entered and left on a falling edge so calls chain back-to-back.
  task automatic do_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] f3, input int waits, input logic [31:0] rd,
                         input logic serr, input string tag);
    bit          legal;
    bit          tout;
    bit          e_err;
    logic [31:0] e_rdata;
    logic [3:0]  e_strb;
    logic [31:0] e_wd;
    logic [71:0] apb_exp;
    logic [71:0] apb_act;
    legal   = req_legal(f3, addr);
    tout    = (waits >= TO);
    e_strb  = exp_strb(we, f3, addr);
    e_wd    = exp_wdata(f3, wdata);
    apb_exp = {we, addr, e_wd, e_strb, f3};

    n_cmp++;
    if (req_ready_o !== 1'b1) begin
      n_bad++;
      $display("FAIL %s ready: got %b want 1", tag, req_ready_o);
    end
    req_valid_i  = 1'b1;
    req_we_i     = we;
    req_addr_i   = addr;
    req_wdata_i  = wdata;
    req_funct3_i = f3;
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i  = 1'b0;
    req_addr_i   = $urandom;
    req_wdata_i  = $urandom;
    req_we_i     = ~we;

    if (!legal) begin
      n_cmp++;
      if ({rsp_valid_o, rsp_err_o, rsp_rdata_o, psel_o, penable_o, req_ready_o} !==
          {1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1}) begin
        n_bad++;
        $display("FAIL %s reject: got v%b e%b d%h sel%b en%b rdy%b want v1 e1 d0 sel0 en0 rdy1",
                 tag, rsp_valid_o, rsp_err_o, rsp_rdata_o, psel_o, penable_o, req_ready_o);
      end
      return;
    end

    n_cmp++;
    apb_act = {pwrite_o, paddr_o, pwdata_o, pstrb_o, pfunct_code_o};
    if ({psel_o, penable_o, req_ready_o, rsp_valid_o} !== 4'b1000 || apb_act !== apb_exp) begin
      n_bad++;
      $display("FAIL %s setup: ctl %b%b%b%b apb %h want ctl 1000 apb %h",
               tag, psel_o, penable_o, req_ready_o, rsp_valid_o, apb_act, apb_exp);
    end

    for (int a = 0; a < TO; a++) begin
      @(negedge clk_i);
      n_cmp++;
      apb_act = {pwrite_o, paddr_o, pwdata_o, pstrb_o, pfunct_code_o};
      if ({psel_o, penable_o, req_ready_o, rsp_valid_o} !== 4'b1100 || apb_act !== apb_exp) begin
        n_bad++;
        $display("FAIL %s access%0d: ctl %b%b%b%b apb %h want ctl 1100 apb %h",
                 tag, a, psel_o, penable_o, req_ready_o, rsp_valid_o, apb_act, apb_exp);
      end
      pready_i  = (a == waits);
      prdata_i  = (a == waits) ? rd : $urandom;
      pslverr_i = (a == waits) ? serr : 1'($urandom_range(0, 1));
      if (a == waits) break;
    end

    @(negedge clk_i);
    pready_i  = 1'b0;
    pslverr_i = 1'b0;
    e_err     = tout || serr;
    e_rdata   = (e_err || we) ? 32'h0 : rd;
    n_cmp++;
    if ({rsp_valid_o, rsp_err_o, rsp_rdata_o, psel_o, penable_o, req_ready_o} !==
        {1'b1, e_err, e_rdata, 1'b0, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL %s rsp: got v%b e%b d%h sel%b en%b rdy%b want v1 e%b d%h sel0 en0 rdy1",
               tag, rsp_valid_o, rsp_err_o, rsp_rdata_o, psel_o, penable_o, req_ready_o,
               e_err, e_rdata);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    n_cmp++;
    if ({psel_o, penable_o, pwrite_o, rsp_valid_o, rsp_err_o, paddr_o, pwdata_o, pstrb_o,
         pfunct_code_o, rsp_rdata_o, req_ready_o} !== {5'b0, 32'h0, 32'h0, 4'h0, 3'b0, 32'h0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_values: sel%b en%b wr%b v%b e%b a%h d%h s%h f%h r%h rdy%b want all 0 rdy1",
               psel_o, penable_o, pwrite_o, rsp_valid_o, rsp_err_o, paddr_o, pwdata_o, pstrb_o,
               pfunct_code_o, rsp_rdata_o, req_ready_o);
    end
    rst_ni = 1'b1;
    @(negedge clk_i);
    n_cmp++;
    if ({rsp_valid_o, psel_o, req_ready_o} !== 3'b001) begin
      n_bad++;
      $display("FAIL reset_release: got v%b sel%b rdy%b want 001", rsp_valid_o, psel_o, req_ready_o);
    end
  endtask

  task automatic test_lw();
    do_xfer(1'b0, 32'h40, 32'h0, 3'b010, 0, 32'hDEADBEEF, 1'b0, "lw_zero_wait");
  endtask

  task automatic test_sb();
    do_xfer(1'b1, 32'h43, 32'h000000A5, 3'b000, 0, 32'h5555AAAA, 1'b0, "sb");
  endtask

  task automatic test_wait_states();
    do_xfer(1'b1, 32'h12, 32'h00001234, 3'b001, 3, 32'h0BADF00D, 1'b0, "sh_wait3");
  endtask

  task automatic test_timeout();
    do_xfer(1'b0, 32'h100, 32'h0, 3'b010, 1000, 32'h11111111, 1'b0, "timeout");
    do_xfer(1'b0, 32'h104, 32'h0, 3'b100, TO - 1, 32'h000000FF, 1'b0, "ready_at_limit");
  endtask

  task automatic test_slverr();
    do_xfer(1'b0, 32'h200, 32'h0, 3'b010, 1, 32'hCAFEF00D, 1'b1, "slverr_load");
    do_xfer(1'b1, 32'h204, 32'h89ABCDEF, 3'b010, 0, 32'h0, 1'b1, "slverr_store");
  endtask

  task automatic test_misaligned();
    do_xfer(1'b0, 32'h2, 32'h0, 3'b010, 0, 32'h0, 1'b0, "lw_misaligned");
    do_xfer(1'b0, 32'h1, 32'h0, 3'b001, 0, 32'h0, 1'b0, "lh_misaligned");
    do_xfer(1'b0, 32'h8, 32'h0, 3'b011, 0, 32'h0, 1'b0, "illegal_011");
    do_xfer(1'b1, 32'hC, 32'h0, 3'b111, 0, 32'h0, 1'b0, "illegal_111");
  endtask

  task automatic test_back_to_back();
    do_xfer(1'b1, 32'h300, 32'h01020304, 3'b010, 0, 32'h0, 1'b0, "b2b_sw");
    do_xfer(1'b0, 32'h300, 32'h0, 3'b101, 0, 32'h00000304, 1'b0, "b2b_lhu");
    do_xfer(1'b1, 32'h301, 32'h0, 3'b001, 0, 32'h0, 1'b0, "b2b_sh_mis");
    do_xfer(1'b0, 32'h302, 32'h0, 3'b000, 0, 32'hFFFFFF80, 1'b0, "b2b_lb");
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      do_xfer(1'($urandom_range(0, 1)), $urandom, $urandom, 3'($urandom_range(0, 7)),
              int'($urandom_range(0, 5)), $urandom, ($urandom_range(0, 7) == 0), "random");
    end
  endtask

  task automatic test_reset_mid_access();
    req_valid_i  = 1'b1;
    req_we_i     = 1'b0;
    req_addr_i   = 32'h80;
    req_funct3_i = 3'b010;
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    pready_i    = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    n_cmp++;
    if ({psel_o, penable_o} !== 2'b11) begin
      n_bad++;
      $display("FAIL midreset_pre: got sel%b en%b want 11", psel_o, penable_o);
    end
    rst_ni = 1'b0;
    #1;
    n_cmp++;
    if ({psel_o, penable_o, rsp_valid_o, req_ready_o} !== 4'b0001) begin
      n_bad++;
      $display("FAIL midreset_async: got sel%b en%b v%b rdy%b want 0001",
               psel_o, penable_o, rsp_valid_o, req_ready_o);
    end
    @(negedge clk_i);
    rst_ni    = 1'b1;
    pready_i  = 1'b1;
    prdata_i  = 32'h12345678;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      n_cmp++;
      if ({rsp_valid_o, psel_o, req_ready_o} !== 3'b001) begin
        n_bad++;
        $display("FAIL midreset_after%0d: got v%b sel%b rdy%b want 001",
                 c, rsp_valid_o, psel_o, req_ready_o);
      end
    end
    pready_i = 1'b0;
    do_xfer(1'b0, 32'h84, 32'h0, 3'b010, 0, 32'h76543210, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sb();
    test_wait_states();
    test_timeout();
    test_slverr();
    test_misaligned();
    test_back_to_back();
    test_random();
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
